// File: rtl/eval_stack_unit.sv
// Parametrised operand/evaluation stack with PUSH/POP/DUP/SWAP and ADD/SUB ALU ops.
// Optional multiplier for op 7 is enabled by defining EVAL_STACK_MUL_EN.
module eval_stack_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] push_val,
    output logic [WIDTH-1:0] top,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [1:0]       state_dbg
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_DUP  = 3'd3;
    localparam logic [2:0] OP_SWAP = 3'd4;
    localparam logic [2:0] OP_ADD  = 3'd5;
    localparam logic [2:0] OP_SUB  = 3'd6;
    localparam logic [2:0] OP_MUL  = 3'd7;

`ifdef EVAL_STACK_MUL_EN
    localparam logic MUL_EN = 1'b1;
`else
    localparam logic MUL_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_DONE} state_t;

    // Handshake: trigger is sampled only in IDLE (busy=0); op/push_val are latched
    // with it. done pulses for one cycle, err/err_code are valid alongside it.
    state_t           state;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] val_r;
    logic [WIDTH-1:0] top_r;
    logic [WIDTH-1:0] next_r;
    logic [CNT_W-1:0] count_r;
    logic             done_r;
    logic             err_r;
    logic [1:0]       err_code_r;

    // The top entry lives in top_r; mem only holds the entries beneath it.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    push_idx;
    logic [AW-1:0]    next_idx;
    logic             mem_we;
    logic [AW-1:0]    mem_wa;
    logic [1:0]       chk_code;
    logic [WIDTH-1:0] alu_res;

    assign push_idx = count_r[AW-1:0] - AW'(1);
    assign next_idx = count_r[AW-1:0] - AW'(2);

    always_comb begin
        chk_code = 2'd0;
        if (op_r == OP_MUL && !MUL_EN)
            chk_code = 2'd3;
        else if (((op_r == OP_POP || op_r == OP_DUP) && count_r == '0) ||
                 (op_r >= OP_SWAP && count_r < CNT_W'(2)))
            chk_code = 2'd2;
        else if ((op_r == OP_PUSH || op_r == OP_DUP) && count_r == CNT_W'(DEPTH))
            chk_code = 2'd1;
    end

    always_comb begin
        case (op_r)
            OP_SUB:  alu_res = next_r - top_r;
`ifdef EVAL_STACK_MUL_EN
            OP_MUL:  alu_res = next_r * top_r;
`endif
            default: alu_res = next_r + top_r;
        endcase
    end

    // Only the old top ever gets written below: on PUSH/DUP it sinks, on SWAP it moves down.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = push_idx;
        if (state == S_READ && chk_code == 2'd0 &&
            (op_r == OP_PUSH || op_r == OP_DUP) && count_r != '0) begin
            mem_we = 1'b1;
        end else if (state == S_EXEC && op_r == OP_SWAP) begin
            mem_we = 1'b1;
            mem_wa = next_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_wa] <= top_r;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            op_r       <= OP_NOP;
            val_r      <= '0;
            top_r      <= '0;
            next_r     <= '0;
            count_r    <= '0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= 2'd0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        op_r       <= op;
                        val_r      <= push_val;
                        err_r      <= 1'b0;
                        err_code_r <= 2'd0;
                        state      <= S_READ;
                    end
                end
                S_READ: begin
                    if (chk_code != 2'd0) begin
                        err_r      <= 1'b1;
                        err_code_r <= chk_code;
                        done_r     <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        case (op_r)
                            OP_NOP: begin
                                done_r <= 1'b1;
                                state  <= S_DONE;
                            end
                            OP_PUSH: begin
                                top_r   <= val_r;
                                count_r <= count_r + CNT_W'(1);
                                done_r  <= 1'b1;
                                state   <= S_DONE;
                            end
                            OP_POP: begin
                                top_r   <= (count_r >= CNT_W'(2)) ? mem[next_idx] : '0;
                                count_r <= count_r - CNT_W'(1);
                                done_r  <= 1'b1;
                                state   <= S_DONE;
                            end
                            OP_DUP: begin
                                count_r <= count_r + CNT_W'(1);
                                done_r  <= 1'b1;
                                state   <= S_DONE;
                            end
                            default: begin
                                next_r <= mem[next_idx];
                                state  <= S_EXEC;
                            end
                        endcase
                    end
                end
                S_EXEC: begin
                    if (op_r == OP_SWAP) begin
                        top_r <= next_r;
                    end else begin
                        top_r   <= alu_res;
                        count_r <= count_r - CNT_W'(1);
                    end
                    done_r <= 1'b1;
                    state  <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign top       = top_r;
    assign count     = count_r;
    assign busy      = (state != S_IDLE);
    assign done      = done_r;
    assign err       = err_r;
    assign err_code  = err_code_r;
    assign state_dbg = state;

endmodule

// File: tb/tb_eval_stack_unit.sv
// Self-checking bench for eval_stack_unit: directed scenarios plus random commands
// compared against a queue-based stack model.
module tb_eval_stack_unit;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

`ifdef EVAL_STACK_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             trigger;
    logic [2:0]       op;
    logic [WIDTH-1:0] push_val;
    logic [WIDTH-1:0] top;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;
    logic             err;
    logic [1:0]       err_code;
    logic [1:0]       state_dbg;

    int n_checks = 0;
    int n_fails  = 0;

    logic [WIDTH-1:0] exp_q[$];

    eval_stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .op(op), .push_val(push_val),
        .top(top), .count(count), .busy(busy), .done(done), .err(err),
        .err_code(err_code), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_top();
        if (exp_q.size() == 0) return '0;
        return exp_q[exp_q.size()-1];
    endfunction

    // Issues one command, updates the model, checks latency, flags and resulting stack.
    task automatic run_cmd(input logic [2:0] c, input logic [WIDTH-1:0] v);
        int n;
        int exp_code;
        int exp_lat;
        int lat;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        n = exp_q.size();
        exp_code = 0;
        if (c == 3'd7 && !MUL_ON) exp_code = 3;
        else if (((c == 3'd2 || c == 3'd3) && n < 1) || (c >= 3'd4 && n < 2)) exp_code = 2;
        else if ((c == 3'd1 || c == 3'd3) && n == DEPTH) exp_code = 1;
        exp_lat = (exp_code == 0 && c >= 3'd4) ? 3 : 2;
        if (exp_code == 0) begin
            case (c)
                3'd1: exp_q.push_back(v);
                3'd2: void'(exp_q.pop_back());
                3'd3: exp_q.push_back(exp_q[n-1]);
                3'd4: begin
                    b = exp_q.pop_back();
                    a = exp_q.pop_back();
                    exp_q.push_back(b);
                    exp_q.push_back(a);
                end
                3'd5, 3'd6, 3'd7: begin
                    b = exp_q.pop_back();
                    a = exp_q.pop_back();
                    if (c == 3'd5) exp_q.push_back(a + b);
                    else if (c == 3'd6) exp_q.push_back(a - b);
                    else exp_q.push_back(a * b);
                end
                default: ;
            endcase
        end

        @(posedge clk); #1;
        trigger  = 1'b1;
        op       = c;
        push_val = v;
        lat = 0;
        while (lat < 8) begin
            @(posedge clk); #1;
            trigger = 1'b0;
            lat++;
            if (done) break;
        end
        check_eq($sformatf("latency op%0d", c), lat, exp_lat);
        check_eq("done", done, 1);
        check_eq("busy_at_done", busy, 1);
        check_eq($sformatf("err op%0d", c), err, (exp_code != 0));
        check_eq($sformatf("err_code op%0d", c), err_code, exp_code);
        check_eq($sformatf("top op%0d", c), top, model_top());
        check_eq($sformatf("count op%0d", c), count, exp_q.size());
        @(posedge clk); #1;
        check_eq("done_pulse_end", done, 0);
        check_eq("idle_after_done", busy, 0);
    endtask

    task automatic drain();
        while (exp_q.size() > 0) run_cmd(3'd2, '0);
    endtask

    initial begin
        int dones;
        logic [2:0] rop;
        rst      = 1'b1;
        trigger  = 1'b0;
        op       = 3'd0;
        push_val = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_top", top, 0);
        check_eq("rst_count", count, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_err_code", err_code, 0);
        check_eq("rst_state", state_dbg, 0);
        rst = 1'b0;

        // Wrapping add chain
        run_cmd(3'd1, 32'hFFFF_FFFF);
        run_cmd(3'd1, 32'd2);
        run_cmd(3'd1, 32'd2);
        run_cmd(3'd5, '0);
        run_cmd(3'd5, '0);
        drain();

        // SUB operand order, SWAP, POP
        run_cmd(3'd1, 32'd10);
        run_cmd(3'd1, 32'd3);
        run_cmd(3'd6, '0);
        run_cmd(3'd1, 32'd5);
        run_cmd(3'd4, '0);
        run_cmd(3'd2, '0);
        drain();

        // Underflow
        run_cmd(3'd2, '0);
        run_cmd(3'd1, 32'd9);
        run_cmd(3'd5, '0);
        run_cmd(3'd4, '0);
        drain();
        run_cmd(3'd3, '0);

        // Overflow at DEPTH
        for (int i = 1; i <= 4; i++) run_cmd(3'd1, WIDTH'(i));
        run_cmd(3'd1, 32'd5);
        run_cmd(3'd3, '0);
        run_cmd(3'd2, '0);
        run_cmd(3'd3, '0);
        run_cmd(3'd0, '0);
        drain();

        // Op 7
        run_cmd(3'd1, 32'd6);
        run_cmd(3'd1, 32'd7);
        run_cmd(3'd7, '0);
        drain();

        // Trigger held high while busy must not start a second command
        exp_q.push_back(32'hA5);
        @(posedge clk); #1;
        trigger  = 1'b1;
        op       = 3'd1;
        push_val = 32'hA5;
        @(posedge clk); #1;
        op    = 3'd2;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            trigger = 1'b0;
            if (done) dones++;
        end
        check_eq("busy_trigger_dones", dones, 1);
        check_eq("busy_trigger_count", count, exp_q.size());
        check_eq("busy_trigger_top", top, model_top());

        // Reset during EXEC of an ADD
        run_cmd(3'd1, 32'd22);
        @(posedge clk); #1;
        trigger = 1'b1;
        op      = 3'd5;
        @(posedge clk); #1;
        trigger = 1'b0;
        @(posedge clk); #1;
        check_eq("in_exec", state_dbg, 2);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        check_eq("midrst_top", top, 0);
        check_eq("midrst_count", count, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_err_code", err_code, 0);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 2) rst = 1'b0;
            if (done) dones++;
        end
        check_eq("midrst_no_done", dones, 0);

        // Random commands
        for (int i = 0; i < 200; i++) begin
            rop = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) rop = 3'd1;
            run_cmd(rop, ($urandom_range(0, 1) == 0) ? WIDTH'($urandom_range(0, 20)) : WIDTH'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
